// File: rtl/pm_reader.sv
// pm_reader: AXI master that programs the performance monitor, polls its
// data-valid flag, reads every sample counter and streams each one out.
module pm_reader #(
  parameter int unsigned evnum    = 64,
  parameter int unsigned poll_gap = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              cfg_sel,
  input  logic [63:0]              cfg_comp,
  input  logic [63:0]              cfg_ctrl,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [$clog2(evnum)-1:0] out_idx,
  output logic [15:0]              m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [63:0]              m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [15:0]              m_axi_araddr,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [63:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);
  localparam int unsigned   iw        = $clog2(evnum);
  localparam int unsigned   gw        = $clog2(poll_gap) + 1;
  localparam logic [iw-1:0] last_idx  = iw'(evnum - 1);
  localparam logic [gw-1:0] gap_last  = gw'(poll_gap - 1);
  localparam logic [15:0]   ctrl_addr = 16'(8 * evnum);
  localparam logic [15:0]   sel_addr  = 16'(8 * (evnum + 1));
  localparam logic [15:0]   comp_addr = 16'(8 * (evnum + 2));

  typedef enum logic [3:0] {
    IDLE, WR_SEL, WR_COMP, WR_CTRL, GAP, POLL, READ, PUSH, DONE
  } state_t;

  state_t        state, state_n;
  logic [63:0]   sel_q, comp_q, ctrl_q;
  logic [iw-1:0] idx;
  logic [gw-1:0] gap_cnt;
  logic          aw_done, w_done, ar_done;
  logic          wr_st, rd_st;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, out_hs;

  assign wr_st  = (state == WR_SEL) || (state == WR_COMP) || (state == WR_CTRL);
  assign rd_st  = (state == POLL) || (state == READ);
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  assign b_hs   = m_axi_bvalid & m_axi_bready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid & m_axi_rready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      comp_q   <= '0;
      ctrl_q   <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ar_done  <= 1'b0;
      err      <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sel_q  <= cfg_sel;
        comp_q <= cfg_comp;
        ctrl_q <= cfg_ctrl;
        err    <= 1'b0;
      end
      if ((b_hs && m_axi_bresp != 2'b00) || (r_hs && m_axi_rresp != 2'b00))
        err <= 1'b1;
      // AW and W retire independently; both flags clear when B closes the write
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (ar_hs) ar_done <= 1'b1;
      if (r_hs)  ar_done <= 1'b0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == POLL && r_hs && m_axi_rdata[0]) idx <= '0;
      if (state == READ && r_hs) begin
        out_data <= m_axi_rdata;
        out_idx  <= idx;
      end
      if (out_hs && idx != last_idx) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = WR_SEL;
      WR_SEL:  if (b_hs) state_n = WR_COMP;
      WR_COMP: if (b_hs) state_n = WR_CTRL;
      WR_CTRL: if (b_hs) state_n = GAP;
      GAP:     if (gap_cnt == gap_last) state_n = POLL;
      POLL:    if (r_hs) state_n = m_axi_rdata[0] ? READ : GAP;
      READ:    if (r_hs) state_n = PUSH;
      PUSH:    if (out_hs) state_n = (idx == last_idx) ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awaddr = '0;
    m_axi_wdata  = '0;
    m_axi_araddr = '0;
    case (state)
      WR_SEL: begin
        m_axi_awaddr = sel_addr;
        m_axi_wdata  = sel_q;
      end
      WR_COMP: begin
        m_axi_awaddr = comp_addr;
        m_axi_wdata  = comp_q;
      end
      WR_CTRL: begin
        m_axi_awaddr = ctrl_addr;
        m_axi_wdata  = ctrl_q & ~64'd1;
      end
      POLL:    m_axi_araddr = ctrl_addr;
      READ:    m_axi_araddr = 16'({idx, 3'b000});
      default: ;
    endcase
    busy          = (state != IDLE) && (state != DONE);
    done          = (state == DONE);
    out_valid     = (state == PUSH);
    m_axi_awvalid = wr_st & ~aw_done;
    m_axi_wvalid  = wr_st & ~w_done;
    m_axi_bready  = wr_st;
    m_axi_arvalid = rd_st & ~ar_done;
    m_axi_rready  = rd_st;
  end
endmodule

// File: tb/tb_pm_reader.sv
// tb_pm_reader: randomized AXI slave / stream sink around pm_reader, checked
// against the expected write, read and output sequences of each run.
module tb_pm_reader;
  localparam int unsigned evnum    = 4;
  localparam int unsigned poll_gap = 2;
  localparam int unsigned iw       = $clog2(evnum);
  localparam logic [15:0] ctrl_a   = 16'(8 * evnum);

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0;
  logic [63:0]   cfg_sel = '0, cfg_comp = '0, cfg_ctrl = '0;
  logic          busy, done, err, out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_data;
  logic [iw-1:0] out_idx;
  logic [15:0]   awaddr, araddr;
  logic [63:0]   wdata;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = '0, rresp = '0;
  logic [63:0]   rdata = '0;

  int total = 0, bad = 0, cyc = 0;

  pm_reader #(.evnum(evnum), .poll_gap(poll_gap)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_sel(cfg_sel), .cfg_comp(cfg_comp),
    .cfg_ctrl(cfg_ctrl), .busy(busy), .done(done), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // slave / sink knobs
  bit          rand_mode = 0;
  int          aw_lag = 0, rerr_idx = -1, stall_idx = -1, stall_len = 0, polls_zero = 0;
  logic [63:0] cnt [evnum];

  // slave state and observations
  bit          aw_got = 0, w_got = 0, rd_pend = 0, err_inj = 0, prev_hold = 0, prev_aw = 0;
  int          lag = 0, b_wait = 0, r_wait = 0, poll_no = 0, stall_cnt = 0, idle = 0;
  int          done_cnt = 0, done_cyc = -2, last_out_edge = -1;
  logic [15:0] aw_a = '0;
  logic [63:0] w_d = '0, r_data_q = '0, hold_d = '0;
  logic [1:0]  b_resp_q = '0, r_resp_q = '0;
  logic [iw-1:0] hold_i = '0;
  logic [15:0] wr_a_q[$], rd_q[$];
  logic [63:0] wr_d_q[$], od_q[$];
  int          oi_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at the falling edge; a handshake seen here fires on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0;
      rresp = '0; rdata = '0; out_ready = 0;
      aw_got = 0; w_got = 0; rd_pend = 0; lag = 0; b_wait = 0; r_wait = 0;
      prev_hold = 0; prev_aw = 0;
    end else begin
      if (w_got) lag++;
      if (aw_got && w_got && b_wait > 0) b_wait--;
      if (rd_pend && r_wait > 0) r_wait--;
      wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      awready = (aw_lag > 0) ? (w_got && lag >= aw_lag)
                             : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      bvalid  = aw_got && w_got && b_wait == 0;
      bresp   = bvalid ? b_resp_q : 2'b00;
      arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid  = rd_pend && r_wait == 0;
      rdata   = rvalid ? r_data_q : '0;
      rresp   = rvalid ? r_resp_q : 2'b00;
      if (out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
        out_ready = 0;
        stall_cnt++;
      end else out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

      if (prev_hold) begin
        chk("out_hold_valid", 64'(out_valid), 64'd1);
        chk("out_hold_data", out_data, hold_d);
        chk("out_hold_idx", 64'(out_idx), 64'(hold_i));
      end
      prev_hold = out_valid && !out_ready;
      hold_d = out_data;
      hold_i = out_idx;
      if (out_valid) chk("no_ar_in_push", 64'(arvalid), 64'd0);
      if (arvalid || rready) chk("ar_aw_excl", 64'(awvalid | wvalid | bready), 64'd0);
      if (awvalid && !prev_aw) chk("aw_w_together", 64'(wvalid), 64'd1);
      prev_aw = awvalid;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
      if (!arvalid && !rready && !bready && busy) idle++;

      if (awvalid && awready) begin
        aw_got = 1; aw_a = awaddr;
      end
      if (wvalid && wready) begin
        w_got = 1; w_d = wdata;
      end
      if ((awvalid && awready) || (wvalid && wready)) begin
        b_wait   = rand_mode ? $urandom_range(0, 2) : 0;
        b_resp_q = (rand_mode && $urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) begin
        wr_a_q.push_back(aw_a);
        wr_d_q.push_back(w_d);
        if (bresp != 2'b00) err_inj = 1;
        aw_got = 0; w_got = 0; lag = 0;
      end
      if (arvalid && arready) begin
        rd_q.push_back(araddr);
        rd_pend  = 1;
        r_wait   = rand_mode ? $urandom_range(0, 2) : 0;
        r_resp_q = (rand_mode && $urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
        if (araddr == ctrl_a) begin
          r_data_q = rand_mode ? {$urandom(), $urandom()} : 64'd0;
          r_data_q[0] = (poll_no >= polls_zero);
          poll_no++;
          chk("poll_spacing", 64'(idle >= int'(poll_gap)), 64'd1);
        end else begin
          r_data_q = cnt[araddr[iw+2:3]];
          if (int'(araddr[iw+2:3]) == rerr_idx) r_resp_q = 2'b10;
        end
        idle = 0;
      end
      if (rvalid && rready) begin
        rd_pend = 0;
        if (rresp != 2'b00) err_inj = 1;
      end
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        oi_q.push_back(int'(out_idx));
        last_out_edge = cyc + 1;
      end
    end
  end

  task automatic begin_run(input int pz);
    wr_a_q.delete(); wr_d_q.delete(); rd_q.delete(); od_q.delete(); oi_q.delete();
    err_inj = 0; done_cnt = 0; poll_no = 0; polls_zero = pz; idle = 0; stall_cnt = 0;
    last_out_edge = -1; done_cyc = -2;
  endtask

  task automatic fill_cnt();
    for (int j = 0; j < int'(evnum); j++) cnt[j] = {$urandom(), $urandom()};
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_axi_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_axi_addr_data", {awaddr, araddr, wdata[31:0]}, 64'd0);
  endtask

  task automatic run_seq(input logic [63:0] s, input logic [63:0] c, input logic [63:0] t,
                         input int pz, input bit restart);
    logic [15:0] ea [3];
    logic [63:0] ed [3];
    int n, nr;
    ea = '{16'(8 * (evnum + 1)), 16'(8 * (evnum + 2)), ctrl_a};
    ed = '{s, c, t & ~64'd1};
    begin_run(pz);
    @(posedge clk); #2;
    cfg_sel = s; cfg_comp = c; cfg_ctrl = t; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cfg_sel = {$urandom(), $urandom()}; cfg_comp = {$urandom(), $urandom()};
    cfg_ctrl = {$urandom(), $urandom()};
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    if (restart) begin
      repeat (2) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (2) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("done_after_last", 64'(done_cyc), 64'(last_out_edge));
    chk("busy_end", 64'(busy), 64'd0);
    chk("err_end", 64'(err), 64'(err_inj));
    chk("wr_count", 64'(wr_a_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < wr_a_q.size(); k++) begin
      chk("wr_addr", 64'(wr_a_q[k]), 64'(ea[k]));
      chk("wr_data", wr_d_q[k], ed[k]);
    end
    nr = pz + 1 + int'(evnum);
    chk("rd_count", 64'(rd_q.size()), 64'(nr));
    for (int k = 0; k < nr && k < rd_q.size(); k++)
      chk("rd_addr", 64'(rd_q[k]), (k <= pz) ? 64'(ctrl_a) : 64'(8 * (k - pz - 1)));
    chk("out_count", 64'(od_q.size()), 64'(evnum));
    for (int k = 0; k < int'(evnum) && k < od_q.size(); k++) begin
      chk("out_data", od_q[k], cnt[k]);
      chk("out_idx", 64'(oi_q[k]), 64'(k));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    #1 rst = 1'b0;

    cnt = '{64'd10, 64'd20, 64'd30, 64'd40};
    run_seq(64'd1, 64'd5, 64'h0000_0007_0000_0000, 2, 0);

    fill_cnt();
    stall_idx = 1; stall_len = 5;
    run_seq({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, 1);
    chk("stall_len", 64'(stall_cnt), 64'd5);
    stall_idx = -1; stall_len = 0;

    fill_cnt();
    aw_lag = 3; rerr_idx = 2;
    run_seq(64'h11, 64'h22, 64'hff, 1, 0);
    chk("err_on_rresp", 64'(err), 64'd1);
    aw_lag = 0; rerr_idx = -1;

    rand_mode = 1;
    for (int r = 0; r < 6; r++) begin
      fill_cnt();
      run_seq({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    fill_cnt();
    begin_run(1);
    @(posedge clk); #2;
    cfg_sel = 64'h5; cfg_comp = 64'h6; cfg_ctrl = 64'h7; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(arvalid && araddr != ctrl_a) && n < 4000);
    chk("reached_read", 64'(arvalid && araddr != ctrl_a), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk);
    #2 rst = 1'b0;

    rand_mode = 0;
    fill_cnt();
    run_seq(64'hA, 64'hB, 64'h0000_0001_0000_0031, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
